// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB PWM duty decoder.
// Channel slices locate each colour's duty inside the 24-bit RGB word.
package rgb_pkg;

    localparam int PWM_STEPS = 256;
    localparam int DUTY_W    = 8;
    localparam int CNT_W     = 9;

    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ONE_EDGE = 2'd1,
        ST_BLINK    = 2'd2
    } blink_state_t;

    // A full window of highs counts 256, which must read as 255, not 0.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [CNT_W-1:0] count);
        return count[CNT_W-1] ? {DUTY_W{1'b1}} : count[DUTY_W-1:0];
    endfunction

endpackage

// File: rtl/pwm_duty_counter.sv
// Per-channel high-time counter over one measurement window.
// Restarts on i_clear while still taking that cycle's sample.
module pwm_duty_counter
    import rgb_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              i_tick,
    input  logic              i_clear,
    input  logic              i_pwm,
    output logic [DUTY_W-1:0] o_duty
);

    logic [CNT_W-1:0] r_count;
    logic             w_hit;

    assign w_hit = i_tick & i_pwm;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= {{(CNT_W-1){1'b0}}, w_hit};
        end else if (w_hit) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_duty = sat_duty(r_count);

endmodule

// File: rtl/rgb_pwm_decoder.sv
// Measures the duty of three PWM inputs over free-running 256-step windows
// and tracks dark/lit alternation to flag a blinking LED.
module rgb_pwm_decoder #(
    parameter int PWM_DIV       = 1,
    parameter int PWM_STEPS     = 256,
    parameter int BLINK_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        pwm_r,
    input  logic        pwm_g,
    input  logic        pwm_b,
    output logic [23:0] rgb_out,
    output logic        rgb_valid,
    output logic [23:0] rgb_lit,
    output logic        dark,
    output logic        blink_det
);
    import rgb_pkg::*;

    localparam logic [15:0] DIV_LAST  = 16'(PWM_DIV - 1);
    localparam logic [7:0]  STEP_LAST = 8'(PWM_STEPS - 1);
    localparam logic [7:0]  TIMEOUT   = 8'(BLINK_TIMEOUT);

    logic [15:0]       r_presc;
    logic [7:0]        r_step;
    logic              r_load;
    logic [23:0]       r_rgb_out;
    logic              r_valid;
    logic [23:0]       r_lit;
    logic              r_dark;
    logic              r_blink;
    logic [7:0]        r_gap;
    blink_state_t      r_state;

    logic              w_tick;
    logic              w_window_end;
    logic [2:0]        w_pwm;
    logic [DUTY_W-1:0] w_duty [3];
    logic [23:0]       w_rgb_new;
    logic              w_dark_new;
    logic              w_transition;
    logic [7:0]        w_gap_inc;

    assign w_tick       = (r_presc == 16'd0);
    assign w_window_end = w_tick && (r_step == STEP_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_presc <= '0;
            r_step  <= '0;
            r_load  <= 1'b0;
        end else begin
            r_presc <= (r_presc == DIV_LAST) ? 16'd0 : r_presc + 16'd1;
            if (w_tick) begin
                r_step <= r_step + 8'd1;
            end
            r_load <= w_window_end;
        end
    end

    assign w_pwm[R_LSB / DUTY_W] = pwm_r;
    assign w_pwm[G_LSB / DUTY_W] = pwm_g;
    assign w_pwm[B_LSB / DUTY_W] = pwm_b;

    // r_load doubles as the counter restart: the counters hold the finished
    // window's totals during that cycle, then begin the next window.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            pwm_duty_counter u_cnt (
                .clk     (clk),
                .n_rst   (n_rst),
                .i_tick  (w_tick),
                .i_clear (r_load),
                .i_pwm   (w_pwm[gi]),
                .o_duty  (w_duty[gi])
            );
            assign w_rgb_new[gi*DUTY_W +: DUTY_W] = w_duty[gi];
        end
    endgenerate

    assign w_dark_new   = (w_rgb_new == 24'd0);
    assign w_transition = (w_dark_new != r_dark);
    assign w_gap_inc    = (r_gap == 8'hFF) ? r_gap : r_gap + 8'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_rgb_out <= '0;
            r_valid   <= 1'b0;
            r_lit     <= '0;
            r_dark    <= 1'b1;
        end else begin
            r_valid <= r_load;
            if (r_load) begin
                r_rgb_out <= w_rgb_new;
                r_dark    <= w_dark_new;
                if (!w_dark_new) begin
                    r_lit <= w_rgb_new;
                end
            end
        end
    end

    // A transition always advances the FSM, even in the window the gap times out.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
            r_gap   <= '0;
            r_blink <= 1'b0;
        end else if (r_load) begin
            if (w_transition) begin
                r_gap <= '0;
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_ONE_EDGE;
                        r_blink <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_BLINK;
                        r_blink <= 1'b1;
                    end
                endcase
            end else begin
                r_gap <= w_gap_inc;
                if (w_gap_inc >= TIMEOUT) begin
                    r_state <= ST_IDLE;
                    r_blink <= 1'b0;
                end
            end
        end
    end

    assign rgb_out   = r_rgb_out;
    assign rgb_valid = r_valid;
    assign rgb_lit   = r_lit;
    assign dark      = r_dark;
    assign blink_det = r_blink;

endmodule
